// File: rtl/reg_hex_pkg.sv
// -----------------------------------------------------------------------------
// reg_hex_pkg
// Shared definitions for the register-to-ASCII-hex streamer:
//   - ASCII constants used by the streamer and the nibble encoder
//   - streamer state enumeration
// Configuration macro: REG_HEX_STREAMER_EOL_EN adds the EOL state
// (CR/LF trailer). When undefined the EOL state does not exist.
// -----------------------------------------------------------------------------
package reg_hex_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;  // '0'
  localparam logic [7:0] ASCII_X  = 8'h78;  // 'x'
  localparam logic [7:0] ASCII_CR = 8'h0D;  // carriage return
  localparam logic [7:0] ASCII_LF = 8'h0A;  // line feed
  localparam logic [7:0] ASCII_UA = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_LA = 8'h61;  // 'a'

`ifdef REG_HEX_STREAMER_EOL_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    DIGIT  = 2'd2,
    EOL    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    DIGIT  = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/hex_nibble_enc.sv
// -----------------------------------------------------------------------------
// hex_nibble_enc
// Purely combinational 4-bit nibble to ASCII hex digit encoder.
// Parameters:
//   UPPER : 1 -> 'A'-'F', 0 -> 'a'-'f' for nibble values 10..15
// Ports:
//   nibble : input  [3:0] value to encode
//   ascii  : output [7:0] ASCII character for the nibble
// -----------------------------------------------------------------------------
module hex_nibble_enc
  import reg_hex_pkg::*;
#(
  parameter int UPPER = 1
) (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  logic [7:0] alpha_base_s;

  assign alpha_base_s = (UPPER != 0) ? ASCII_UA : ASCII_LA;

  // Digits 0-9 map onto '0'..'9'; 10-15 map onto the selected letter range.
  always_comb begin
    if (nibble < 4'd10) begin
      ascii = ASCII_0 + {4'b0000, nibble};
    end else begin
      ascii = alpha_base_s + {4'b0000, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/reg_hex_streamer.sv
// -----------------------------------------------------------------------------
// reg_hex_streamer
// Formats a DATA_W-bit register value as a stream of ASCII hex characters on
// a valid/ready byte interface: optional "0x" prefix, DATA_W/4 digits (MS
// nibble first, leading zeros kept) and, when REG_HEX_STREAMER_EOL_EN is
// defined, a CR/LF trailer. A one-cycle done pulse follows the final byte.
// Parameters:
//   DATA_W    : register width, multiple of 4 in 4..64
//   UPPER     : 1 -> upper-case letters, 0 -> lower-case letters
//   PREFIX_EN : 1 -> emit "0x" before the digits
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   start     : request to format regdata (accepted only when idle)
//   regdata   : value to format, captured on the accepting edge
//   busy      : high whenever the streamer is not idle
//   out_valid : out_data holds a valid ASCII byte
//   out_ready : sink accepts the byte
//   out_data  : ASCII byte
//   done      : one-cycle completion pulse, asserted while already idle
// Configuration macro: REG_HEX_STREAMER_EOL_EN
// -----------------------------------------------------------------------------
module reg_hex_streamer
  import reg_hex_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int UPPER     = 1,
  parameter int PREFIX_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] regdata,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              done
);

  localparam int NDIG  = DATA_W / 4;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  generate
    if ((DATA_W < 4) || (DATA_W > 64) || ((DATA_W % 4) != 0)) begin : g_bad_data_w
      $error("reg_hex_streamer: DATA_W must be a multiple of 4 in 4..64");
    end
  endgenerate

  // Registered state
  state_t            state_r;
  logic [DATA_W-1:0] shadow_r;
  logic [IDX_W-1:0]  idx_r;
  logic              sub_r;      // position within the two-byte prefix / EOL
  logic              busy_r;
  logic              out_valid_r;
  logic [7:0]        out_data_r;
  logic              done_r;

  // Next-state values
  state_t            state_n;
  logic [DATA_W-1:0] shadow_n;
  logic [IDX_W-1:0]  idx_n;
  logic              sub_n;
  logic              done_n;
  logic [7:0]        byte_n;

  logic              xfer_s;
  logic [DATA_W-1:0] shifted_s;
  logic [3:0]        nibble_s;
  logic [7:0]        enc_s;

  assign xfer_s = out_valid_r & out_ready;

  // Next-state logic: advance only on a completed byte transfer.
  always_comb begin
    state_n  = state_r;
    shadow_n = shadow_r;
    idx_n    = idx_r;
    sub_n    = sub_r;
    done_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          shadow_n = regdata;
          idx_n    = {IDX_W{1'b0}};
          sub_n    = 1'b0;
          state_n  = (PREFIX_EN != 0) ? PREFIX : DIGIT;
        end else begin
          state_n  = IDLE;
        end
      end
      PREFIX: begin
        if (xfer_s) begin
          if (sub_r) begin
            state_n = DIGIT;
            sub_n   = 1'b0;
          end else begin
            sub_n   = 1'b1;
          end
        end else begin
          state_n = PREFIX;
        end
      end
      DIGIT: begin
        if (xfer_s) begin
          if (idx_r == LAST_IDX) begin
`ifdef REG_HEX_STREAMER_EOL_EN
            state_n = EOL;
            sub_n   = 1'b0;
`else
            state_n = IDLE;
            done_n  = 1'b1;
`endif
          end else begin
            idx_n = idx_r + IDX_W'(1);
          end
        end else begin
          state_n = DIGIT;
        end
      end
`ifdef REG_HEX_STREAMER_EOL_EN
      EOL: begin
        if (xfer_s) begin
          if (sub_r) begin
            state_n = IDLE;
            sub_n   = 1'b0;
            done_n  = 1'b1;
          end else begin
            sub_n   = 1'b1;
          end
        end else begin
          state_n = EOL;
        end
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The output byte is precomputed from the next state so that out_data is a
  // register and is already correct in the cycle after the accepting edge.
  assign shifted_s = shadow_n << {idx_n, 2'b00};
  assign nibble_s  = shifted_s[DATA_W-1 -: 4];

  hex_nibble_enc #(
    .UPPER (UPPER)
  ) u_enc (
    .nibble (nibble_s),
    .ascii  (enc_s)
  );

  // Byte to present next cycle, selected by next state and sub-position.
  always_comb begin
    byte_n = 8'h00;
    case (state_n)
      IDLE:    byte_n = 8'h00;
      PREFIX:  byte_n = sub_n ? ASCII_X : ASCII_0;
      DIGIT:   byte_n = enc_s;
`ifdef REG_HEX_STREAMER_EOL_EN
      EOL:     byte_n = sub_n ? ASCII_LF : ASCII_CR;
`endif
      default: byte_n = 8'h00;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shadow_r    <= {DATA_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      sub_r       <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      shadow_r    <= shadow_n;
      idx_r       <= idx_n;
      sub_r       <= sub_n;
      busy_r      <= (state_n != IDLE);
      out_valid_r <= (state_n != IDLE);
      out_data_r  <= byte_n;
      done_r      <= done_n;
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign done      = done_r;

endmodule

// File: tb/tb_reg_hex_streamer.sv
// -----------------------------------------------------------------------------
// tb_reg_hex_streamer
// Directed self-checking bench. Three instances share clock and reset:
//   u_dut0 : DATA_W=32, UPPER=1, PREFIX_EN=0
//   u_dut1 : DATA_W=32, UPPER=0, PREFIX_EN=0
//   u_dut2 : DATA_W=12, UPPER=1, PREFIX_EN=1 (CR/LF expected when
//            REG_HEX_STREAMER_EOL_EN is defined)
// Expected bytes are pushed to a queue when a stream is started and popped as
// the sink accepts each byte. Inputs change and outputs are sampled at the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_reg_hex_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_b;
  logic [2:0]  ready_b;
  logic [2:0]  busy_b;
  logic [2:0]  valid_b;
  logic [2:0]  done_b;
  logic [7:0]  data0, data1, data2;
  logic [31:0] rd0, rd1;
  logic [11:0] rd2;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  reg_hex_streamer #(.DATA_W(32), .UPPER(1), .PREFIX_EN(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_b[0]), .regdata(rd0),
    .busy(busy_b[0]), .out_valid(valid_b[0]), .out_ready(ready_b[0]),
    .out_data(data0), .done(done_b[0]));

  reg_hex_streamer #(.DATA_W(32), .UPPER(0), .PREFIX_EN(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_b[1]), .regdata(rd1),
    .busy(busy_b[1]), .out_valid(valid_b[1]), .out_ready(ready_b[1]),
    .out_data(data1), .done(done_b[1]));

  reg_hex_streamer #(.DATA_W(12), .UPPER(1), .PREFIX_EN(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_b[2]), .regdata(rd2),
    .busy(busy_b[2]), .out_valid(valid_b[2]), .out_ready(ready_b[2]),
    .out_data(data2), .done(done_b[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit up);
    string s;
    s = up ? "0123456789ABCDEF" : "0123456789abcdef";
    return s[n];
  endfunction

  function automatic logic [7:0] data_of(input int k);
    case (k)
      0:       return data0;
      1:       return data1;
      default: return data2;
    endcase
  endfunction

  task automatic set_rd(input int k, input logic [63:0] v);
    case (k)
      0:       rd0 = v[31:0];
      1:       rd1 = v[31:0];
      default: rd2 = v[11:0];
    endcase
  endtask

  // Start a stream on instance k at the current falling edge and consume it.
  // stall_at/stall_len: hold ready low for stall_len cycles before byte
  // number stall_at (0-based). restart_at: re-assert start with all-ones
  // after that many bytes. abort_after: return once that many bytes are
  // committed to transfer (the caller then applies reset).
  task automatic run(input int k, input logic [63:0] val, input int stall_at,
                     input int stall_len, input int restart_at, input int abort_after,
                     output int got, output int lat);
    int  nd, nexp, stalled, exp_lat;
    bit  up, pre, eol, restarted;
    logic [7:0] e;
    nd  = (k == 2) ? 3 : 8;
    up  = (k != 1);
    pre = (k == 2);
    eol = 1'b0;
`ifdef REG_HEX_STREAMER_EOL_EN
    if (k == 2) eol = 1'b1;
`endif
    exp_q.delete();
    if (pre) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    for (int i = nd - 1; i >= 0; i--) exp_q.push_back(hexc(val[4*i +: 4], up));
    if (eol) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
    nexp      = exp_q.size();
    exp_lat   = nexp + 1 + ((stall_at >= 0) ? stall_len : 0);
    got       = 0;
    lat       = 0;
    stalled   = 0;
    restarted = 1'b0;
    set_rd(k, val);
    start_b[k] = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start_b[k] = 1'b0;
      if (done_b[k]) begin
        lat = cyc;
        break;
      end
      if (restart_at >= 0 && got == restart_at && !restarted) begin
        set_rd(k, 64'hFFFF_FFFF_FFFF_FFFF);
        start_b[k] = 1'b1;
        restarted  = 1'b1;
      end
      if (stall_at >= 0 && got == stall_at && stalled < stall_len) begin
        ready_b[k] = 1'b0;
        stalled++;
        chk("stall_valid", {63'd0, valid_b[k]}, 64'd1);
        chk("stall_data", {56'd0, data_of(k)}, {56'd0, exp_q[0]});
      end else begin
        ready_b[k] = 1'b1;
      end
      if (valid_b[k] && ready_b[k]) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", {56'd0, data_of(k)}, 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("byte%0d_k%0d", got, k), {56'd0, data_of(k)}, {56'd0, e});
        end
        got++;
        if (abort_after >= 0 && got == abort_after) begin
          exp_q.delete();
          return;
        end
      end
    end
    if (lat == 0) begin
      chk("timeout_no_done", 64'd0, 64'd1);
    end else begin
      chk("done_busy_low", {63'd0, busy_b[k]}, 64'd0);
      chk("done_valid_low", {63'd0, valid_b[k]}, 64'd0);
      chk("byte_count", 64'(got), 64'(nexp));
      chk("latency", 64'(lat), 64'(exp_lat));
    end
  endtask

  initial begin
    int got, lat;
    rst_n   = 1'b0;
    start_b = 3'b000;
    ready_b = 3'b111;
    rd0 = 32'h0;
    rd1 = 32'h0;
    rd2 = 12'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {61'd0, busy_b}, 64'd0);
    chk("rst_valid", {61'd0, valid_b}, 64'd0);
    chk("rst_done", {61'd0, done_b}, 64'd0);
    chk("rst_data0", {56'd0, data0}, 64'd0);
    chk("rst_data2", {56'd0, data2}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Upper-case, ready held high: DEADBEEF
    run(0, 64'hDEAD_BEEF, -1, 0, -1, -1, got, lat);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done_b[0]}, 64'd0);

    // Lower-case with leading and embedded zeros
    run(1, 64'h00A0_F009, -1, 0, -1, -1, got, lat);
    @(negedge clk);

    // Back-pressure on the third byte
    run(0, 64'h1234_5678, 2, 3, -1, -1, got, lat);
    @(negedge clk);

    // Start while busy is ignored; start in the done cycle is accepted
    run(0, 64'h1111_1111, -1, 0, 2, -1, got, lat);
    run(0, 64'hFFFF_FFFF, -1, 0, -1, -1, got, lat);
    @(negedge clk);

    // Reset after the fourth byte abandons the stream without done
    run(0, 64'hCAFE_F00D, -1, 0, -1, 4, got, lat);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {63'd0, busy_b[0]}, 64'd0);
    chk("mid_rst_valid", {63'd0, valid_b[0]}, 64'd0);
    chk("mid_rst_done", {63'd0, done_b[0]}, 64'd0);
    chk("mid_rst_data", {56'd0, data0}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", {63'd0, done_b[0]}, 64'd0);
    run(0, 64'h0000_000F, -1, 0, -1, -1, got, lat);
    @(negedge clk);

    // 12-bit instance with prefix (and CR/LF when enabled)
    run(2, 64'h7C3, -1, 0, -1, -1, got, lat);
    @(negedge clk);
    chk("w12_done_one_cycle", {63'd0, done_b[2]}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
